// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters and the rr_arbiter8 round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout_err;
  logic [2:0] last;

  modport master (
    output req, done,
    input  gnt, gnt_valid, timeout_err, last
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, timeout_err, last
  );
endinterface

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with grant hold, release on DONE/request drop, and timeout.
// Grant is registered and always one-hot or zero so the downstream encoder never sees multi-hot.
module rr_arbiter8 #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter8_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [2:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    gnt_q, gnt_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_err_q, timeout_err_d;

  logic [2:0]    idx;
  logic [2:0]    winner;
  logic          found;
  logic          clean_release;
  logic          timeout_hit;

  // Search starts one past the previous winner and ends on the previous winner itself.
  always_comb begin
    idx    = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign clean_release = bus.done || !bus.req[last_q];
  assign timeout_hit   = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_d = 8'h00;
        if (found) begin
          gnt_d   = 8'h01 << winner;
          last_d  = winner;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      default: begin
        if (clean_release || timeout_hit) begin
          gnt_d         = 8'h00;
          state_d       = ST_IDLE;
          timeout_err_d = timeout_hit && !clean_release;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    gnt_valid_d = (gnt_d != 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_q        <= 3'b111;
      cnt_q         <= '0;
      gnt_q         <= 8'h00;
      gnt_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      gnt_valid_q   <= gnt_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_valid   = gnt_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.last        = last_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and randomized bench for rr_arbiter8 against a per-cycle behavioural model
// that tracks owner index and hold length in plain integers.
module tb_rr_arbiter8;
  localparam int TO = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Reference model state
  int   m_owner;
  int   m_last;
  int   m_held;
  bit   m_terr;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.TIMEOUT(TO), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    m_owner = -1;
    m_last  = 7;
    m_held  = 0;
    m_terr  = 1'b0;
  endtask

  task automatic modelEdge(input logic [7:0] r, input logic d);
    bit clean;
    bit tmo;
    bit hit;
    m_terr = 1'b0;
    if (m_owner < 0) begin
      hit = 1'b0;
      for (int j = 1; j <= 8; j++) begin
        if (!hit && r[(m_last + j) % 8]) begin
          hit     = 1'b1;
          m_owner = (m_last + j) % 8;
        end
      end
      if (hit) begin
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      clean = d || !r[m_owner];
      tmo   = (TO != 0) && (m_held == TO);
      if (clean || tmo) begin
        m_terr  = tmo && !clean;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  function automatic logic [7:0] modelGnt();
    logic [7:0] g;
    g = 8'h00;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction

  task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] eg;
    eg = modelGnt();
    checkValue({tag, ".gnt"}, bus.gnt, eg);
    checkValue({tag, ".valid"}, {7'b0, bus.gnt_valid}, {7'b0, (eg != 8'h00)});
    checkValue({tag, ".terr"}, {7'b0, bus.timeout_err}, {7'b0, m_terr});
    checkValue({tag, ".last"}, {5'b0, bus.last}, 8'(m_last));
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic d, input string tag);
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    modelEdge(r, d);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] rq;
    logic       dn;
    int         hold;
    total = 0;
    bad   = 0;
    modelReset();

    // Reset with all requests asserted
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    rst_n = 1'b1;

    // Full rotation with DONE held high
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'hFF, 1'b1, "rotate");
      if (i % 2 == 0) checkValue("rotate.onehot", bus.gnt, 8'h01 << (i / 2));
      else            checkValue("rotate.idle", bus.gnt, 8'h00);
    end
    checkValue("rotate.last7", {5'b0, bus.last}, 8'd7);

    // Wrap priority from LAST = 7
    applyStimulus(8'h81, 1'b1, "wrap1");
    checkValue("wrap.first", bus.gnt, 8'h01);
    applyStimulus(8'h81, 1'b1, "wrap2");
    applyStimulus(8'h81, 1'b1, "wrap3");
    checkValue("wrap.second", bus.gnt, 8'h80);
    applyStimulus(8'h81, 1'b1, "wrap4");
    applyStimulus(8'h81, 1'b1, "wrap5");
    checkValue("wrap.third", bus.gnt, 8'h01);

    // Timeout with requester 4 holding
    for (int i = 0; i < 5; i++) begin
      if (bus.gnt == 8'h10) break;
      applyStimulus(8'h10, 1'b0, "to.wait");
    end
    checkValue("to.granted", bus.gnt, 8'h10);
    hold = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.gnt != 8'h10) break;
      hold++;
      applyStimulus(8'h10, 1'b0, "to.hold");
    end
    checkValue("to.length", 8'(hold), 8'(TO));
    checkValue("to.err", {7'b0, bus.timeout_err}, 8'h01);
    applyStimulus(8'h10, 1'b0, "to.regrant");
    checkValue("to.regrant", bus.gnt, 8'h10);
    checkValue("to.errclr", {7'b0, bus.timeout_err}, 8'h00);

    // DONE coincident with the final timeout cycle
    for (int i = 0; i < TO - 1; i++) applyStimulus(8'h10, 1'b0, "sim.hold");
    checkValue("sim.still", bus.gnt, 8'h10);
    applyStimulus(8'h10, 1'b1, "sim.done");
    checkValue("sim.gnt", bus.gnt, 8'h00);
    checkValue("sim.noerr", {7'b0, bus.timeout_err}, 8'h00);

    // Owner drops its request
    applyStimulus(8'h10, 1'b0, "drop.grant");
    applyStimulus(8'h00, 1'b0, "drop.rel");
    checkValue("drop.gnt", bus.gnt, 8'h00);
    checkValue("drop.noerr", {7'b0, bus.timeout_err}, 8'h00);

    // Non-preemption and next-winner order
    applyStimulus(8'h04, 1'b0, "np.grant");
    checkValue("np.g2", bus.gnt, 8'h04);
    for (int i = 0; i < 3; i++) applyStimulus(8'h05, 1'b0, "np.hold");
    checkValue("np.kept", bus.gnt, 8'h04);
    applyStimulus(8'h05, 1'b1, "np.done");
    applyStimulus(8'h09, 1'b0, "np.next");
    checkValue("np.r3first", bus.gnt, 8'h08);
    applyStimulus(8'h09, 1'b1, "np.done2");
    applyStimulus(8'h01, 1'b0, "np.r0");
    checkValue("np.r0", bus.gnt, 8'h01);

    // Asynchronous reset mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkValue("areset.gnt", bus.gnt, 8'h00);
    checkValue("areset.valid", {7'b0, bus.gnt_valid}, 8'h00);
    checkValue("areset.last", {5'b0, bus.last}, 8'd7);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1'b1, "areset.restart");
    checkValue("areset.r0", bus.gnt, 8'h01);

    // Randomized traffic, requests mostly stable so holds and timeouts occur
    rq = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom);
      dn = ($urandom_range(0, 9) == 0);
      applyStimulus(rq, dn, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
